// File: rtl/byte_pair_pkg.sv
// Shared types for the byte-pair consumer: byte/word types, pair FSM states, packing helper.
// Combinational helper only; no state.
// No flow control here; used by pair_fifo and byte_pair_consumer.
package byte_pair_pkg;
    localparam int WORD_W = 16;

    typedef logic [7:0]        byte_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } pair_state_e;

    // The first byte of a pair lands in the low half when lsb_first is set.
    function automatic word_t pack_pair(input byte_t first, input byte_t second, input bit lsb_first);
        return lsb_first ? {second, first} : {first, second};
    endfunction
endpackage

// File: rtl/pair_fifo.sv
// Generic word FIFO with synchronous clear; head is zero while empty.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push is ignored when full, pop is ignored when empty; flush wins over both.
module pair_fifo
    import byte_pair_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  word_t                  push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output word_t                  head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    word_t              mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/byte_pair_consumer.sv
// Packs byte pairs into 16-bit words and queues them; BYTE_PAIR_CONSUMER_STATS_EN adds word_cnt.
// Latency: second byte accepted at cycle N gives result_valid at N+1 (empty FIFO).
// Backpressure: data_ready drops only in WAIT_SECOND with a full FIFO; a same-cycle pop frees space next cycle.
module byte_pair_consumer
    import byte_pair_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  byte_t       data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        flush,
    output word_t       result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic        pair_err
`ifdef BYTE_PAIR_CONSUMER_STATS_EN
    ,
    output logic [15:0] word_cnt
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    pair_state_e       state;
    pair_state_e       state_nxt;
    byte_t             hold;
    logic              accept;
    logic              push;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= WAIT_FIRST;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = WAIT_FIRST;
        end else if (accept) begin
            state_nxt = (state == WAIT_FIRST) ? WAIT_SECOND : WAIT_FIRST;
        end
    end

    // Outputs: readiness comes from registered state only, never from result_ready.
    always_comb begin
        data_ready = (state == WAIT_FIRST) | (fifo_count < CNT_W'(DEPTH));
        accept     = data_valid & data_ready;
        push       = accept & (state == WAIT_SECOND) & ~flush & ~fifo_full;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold     <= '0;
            pair_err <= 1'b0;
        end else begin
            pair_err <= flush & (state == WAIT_SECOND);
            if (flush)                               hold <= '0;
            else if (accept && state == WAIT_FIRST)  hold <= data_in;
        end
    end

`ifdef BYTE_PAIR_CONSUMER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n)    word_cnt <= '0;
        else if (push) word_cnt <= word_cnt + 16'd1;
    end
`endif

    pair_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (pack_pair(hold, data_in, LSB_FIRST)),
        .pop      (result_valid & result_ready),
        .flush    (flush),
        .head     (result),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign result_valid = ~fifo_empty;
endmodule
